data_mem_port_ctrl: RTL and testbench
=====================================

# data_mem_port_ctrl

- Load/store initiator for the data side (port B) of the RAM subsystem.
- Accepts one memory request per handshake from the execute stage and drives the port-B controls to the RAM (`alu`, `din`, `memOp`, `memSize`, `enB`).
- Holds each request until the RAM signals `ready`, waits for `readValidB` on loads, and returns tagged load data to register writeback.
- Checks alignment, response address and timeouts; one request outstanding at a time.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT_RD before abort; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  execute-stage request valid.
- req_ready  out  1  block can accept a request.
- req_op  in  2  00 disable, 01 read-sext, 10 read-zext, 11 write.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  destination register tag for loads.
- alu  out  32  port-B address to RAM.
- din  out  32  port-B write data to RAM.
- memOp  out  2  port-B operation to RAM.
- memSize  out  2  port-B size to RAM.
- enB  out  1  port-B enable.
- ready  in  1  RAM accepts the port-B request this cycle.
- doutB  in  32  RAM load data, already extended by RAM.
- readValidB  in  1  doutB valid.
- addrBOut  in  32  address associated with doutB.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  5  writeback tag.
- wb_data  out  32  writeback data.
- err_valid  out  1  one-cycle error strobe.
- err_code  out  2  01 misaligned/illegal size, 10 address mismatch, 11 timeout.
- err_addr  out  32  request address of the failing access.

## Operation
Reset:
- All outputs 0; state IDLE.
- `memOp` = 00, `memSize` = 00; timeout counter cleared.

States:
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, the request fields are registered.
  - op 00 → stays in IDLE; no RAM access, no writeback.
  - Illegal request with the trap enabled (see Configuration) → ERR.
  - Otherwise → ISSUE.
- ISSUE:
  - `enB` = 1; `alu`, `din`, `memOp`, `memSize` driven from registers and held stable.
  - `req_ready` = 0.
  - `ready` sampled 1: write → IDLE; read → WAIT_RD with the counter cleared.
- WAIT_RD:
  - `enB` = 0; the counter increments each cycle.
  - `readValidB` = 1 and `addrBOut` equals the registered address:
    - Next cycle: `wb_valid` = 1, `wb_rd` = tag, `wb_data` = `doutB`.
    - → IDLE.
  - `readValidB` = 1 with a mismatched address:
    - Next cycle: `wb_valid` = 1 with the data.
    - Same cycle: `err_valid` = 1, code 10.
    - → IDLE.
  - Counter reaches TIMEOUT_CYCLES with no `readValidB` → `err_valid`, code 11, no writeback → IDLE.
- ERR:
  - One cycle; `err_valid` = 1, code 01, `err_addr` = request address → IDLE.
  - No RAM access.

Other rules:
- `readValidB` outside WAIT_RD is ignored.
- `din` is zero-masked to the size: byte keeps `[7:0]`, halfword keeps `[15:0]`.
- Misaligned means any of:
  - halfword with `addr[0]` = 1;
  - word with `addr[1:0]` ≠ 00;
  - size 11.
- Async reset mid-request drops the request with no writeback and no error.

## Timing
- Accept at edge N → `enB` high during cycle N+1.
- Store: completes on the first edge with `ready` = 1; minimum 2 cycles accept-to-accept.
- Load:
  - `readValidB` sampled at edge M → `wb_valid` during cycle M+1.
  - Minimum accept-to-writeback latency is 3 cycles.
- `req_ready` rises the cycle after completion.
- `wb_valid` and `err_valid` are single-cycle pulses; they never repeat for one request.
- Back-to-back requests never overlap; no new `enB` is asserted before the prior request completes.

## Configuration
`DMEM_MISALIGN_TRAP_EN`:
- Defined: misaligned or illegal-size requests go to ERR (code 01) and are never issued to the RAM.
- Undefined:
  - Such requests are issued unchanged; size 11 is issued as word.
  - No code-01 error exists.
  - `err_code` never takes 01.

## Test plan
- Store word 0xDEADBEEF @0x80000000, then read-zext word @0x80000000 with tag 5 → `wb_valid` once, `wb_rd` = 5, `wb_data` = 0xDEADBEEF.
- Store halfword 0x00008765 @0x80000020, read-zext halfword → `wb_data` = 0x00008765; read-sext byte @0x80000020 → 0x00000065.
- Hold `ready` low 4 cycles during a store @0x80000010 → `enB`, `alu` and `din` stable all 4 cycles; `req_ready` = 0 throughout; completion on the first `ready`.
- Load @0x80000004 with `readValidB` withheld, TIMEOUT_CYCLES = 16 → `err_valid`, code 11, `err_addr` = 0x80000004; no `wb_valid`.
- Word read @0x80000002 with macro defined → `err_valid`, code 01, `enB` never asserted; without macro → `enB` asserted with `alu` = 0x80000002.
- Load @0x80000060 returning `addrBOut` = 0x80000064 → `wb_valid` plus `err_valid`, code 10; assert `rst_n` low during WAIT_RD → all outputs 0 and `req_ready` = 1 after release.

Source files
------------

// File: rtl/data_mem_port_ctrl.sv
// Port-B load/store initiator: one outstanding request, holds controls until ready, returns tagged load data.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned/illegal-size requests raise error code 01 instead of issuing.
module data_mem_port_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] alu,
  output logic [31:0] din,
  output logic [1:0]  memOp,
  output logic [1:0]  memSize,
  output logic        enB,
  input  logic        ready,
  input  logic [31:0] doutB,
  input  logic        readValidB,
  input  logic [31:0] addrBOut,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, ERR} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d, size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wb_valid_q, wb_valid_d, err_valid_q, err_valid_d;
  logic [31:0] wb_data_q, wb_data_d, err_addr_q, err_addr_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] wdata_masked;

  always_comb begin
    case (req_size)
      2'b00:   wdata_masked = {24'd0, req_wdata[7:0]};
      2'b01:   wdata_masked = {16'd0, req_wdata[15:0]};
      default: wdata_masked = req_wdata;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    err_addr_d  = err_addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = wdata_masked;
          rd_d    = req_rd;
          if (req_op != 2'b00) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            if (misaligned) begin
              // Error strobe is registered so it lands in the single ERR cycle.
              state_d     = ERR;
              err_valid_d = 1'b1;
              err_code_d  = 2'b01;
              err_addr_d  = req_addr;
            end else begin
              state_d = ISSUE;
            end
`else
            state_d = ISSUE;
`endif
          end
        end
      end
      ISSUE: begin
        if (ready) begin
          if (op_q == 2'b11) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_RD;
            cnt_d   = 8'd0;
          end
        end
      end
      WAIT_RD: begin
        if (readValidB) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = doutB;
          if (addrBOut != addr_q) begin
            err_valid_d = 1'b1;
            err_code_d  = 2'b10;
            err_addr_d  = addr_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_LIM) begin
            state_d     = IDLE;
            err_valid_d = 1'b1;
            err_code_d  = 2'b11;
            err_addr_d  = addr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      size_q      <= 2'b00;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rd_q        <= 5'd0;
      cnt_q       <= 8'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
      err_addr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Port-B controls are zero outside ISSUE; size 11 goes out as a word access.
  assign req_ready = (state_q == IDLE);
  assign enB       = (state_q == ISSUE);
  assign alu       = enB ? addr_q  : 32'd0;
  assign din       = enB ? wdata_q : 32'd0;
  assign memOp     = enB ? op_q    : 2'b00;
  assign memSize   = !enB ? 2'b00 : ((size_q == 2'b11) ? 2'b10 : size_q);
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_data_mem_port_ctrl.sv
// Directed bench for data_mem_port_ctrl: vector table of single accesses plus multi-cycle corner sequences.
module tb_data_mem_port_ctrl;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op, req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] alu, din;
  logic [1:0]  memOp, memSize;
  logic        enB, ready;
  logic [31:0] doutB, addrBOut;
  logic        readValidB;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  int n_total = 0;
  int n_pass  = 0;

  data_mem_port_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .alu(alu), .din(din), .memOp(memOp), .memSize(memSize), .enB(enB),
    .ready(ready), .doutB(doutB), .readValidB(readValidB), .addrBOut(addrBOut),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] exp_din;
    logic [1:0]  exp_size;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; afterwards the DUT has taken it.
  task automatic start_req(input logic [1:0] op, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    step();
    req_valid = 1'b0;
    req_op    = 2'b00;
  endtask

  int k;
  int wb_seen;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_size = 2'b00;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    ready = 1'b0; doutB = 32'd0; readValidB = 1'b0; addrBOut = 32'd0;

    vecs[0] = '{2'b11, 2'b10, 32'h8000_0000, 32'hDEAD_BEEF, 5'd0,  32'd0,          32'hDEAD_BEEF, 2'b10};
    vecs[1] = '{2'b10, 2'b10, 32'h8000_0000, 32'd0,        5'd5,  32'hDEAD_BEEF,  32'd0,         2'b10};
    vecs[2] = '{2'b11, 2'b01, 32'h8000_0020, 32'h1234_8765, 5'd0, 32'd0,          32'h0000_8765, 2'b01};
    vecs[3] = '{2'b10, 2'b01, 32'h8000_0020, 32'd0,        5'd7,  32'h0000_8765,  32'd0,         2'b01};
    vecs[4] = '{2'b01, 2'b00, 32'h8000_0020, 32'd0,        5'd9,  32'h0000_0065,  32'd0,         2'b00};
    vecs[5] = '{2'b11, 2'b00, 32'h8000_0033, 32'hAABB_CCDD, 5'd0, 32'd0,          32'h0000_00DD, 2'b00};
    vecs[6] = '{2'b01, 2'b01, 32'h8000_0012, 32'd0,        5'd31, 32'hFFFF_8000,  32'd0,         2'b01};

    #12;
    chk("rst_enB", 32'(enB), 32'd0);
    chk("rst_memOp", 32'(memOp), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_alu", alu, 32'd0);

    for (int i = 0; i < 7; i++) begin
      start_req(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].rd);
      chk("issue_enB", 32'(enB), 32'd1);
      chk("issue_req_ready", 32'(req_ready), 32'd0);
      chk("issue_alu", alu, vecs[i].addr);
      chk("issue_din", din, vecs[i].exp_din);
      chk("issue_memOp", 32'(memOp), 32'(vecs[i].op));
      chk("issue_memSize", 32'(memSize), 32'(vecs[i].exp_size));
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("post_issue_enB", 32'(enB), 32'd0);
      if (vecs[i].op == 2'b11) begin
        chk("store_done_ready", 32'(req_ready), 32'd1);
      end else begin
        chk("wait_req_ready", 32'(req_ready), 32'd0);
        readValidB = 1'b1; doutB = vecs[i].rdata; addrBOut = vecs[i].addr;
        step();
        readValidB = 1'b0;
        chk("ld_wb_valid", 32'(wb_valid), 32'd1);
        chk("ld_wb_rd", 32'(wb_rd), 32'(vecs[i].rd));
        chk("ld_wb_data", wb_data, vecs[i].rdata);
        chk("ld_err_valid", 32'(err_valid), 32'd0);
        chk("ld_req_ready", 32'(req_ready), 32'd1);
        step();
        chk("ld_wb_pulse", 32'(wb_valid), 32'd0);
      end
    end

    // Store stalled by ready low for 4 cycles.
    start_req(2'b11, 2'b10, 32'h8000_0010, 32'h0BAD_F00D, 5'd0);
    for (int c = 0; c < 4; c++) begin
      chk("stall_enB", 32'(enB), 32'd1);
      chk("stall_alu", alu, 32'h8000_0010);
      chk("stall_din", din, 32'h0BAD_F00D);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("stall_done_enB", 32'(enB), 32'd0);
    chk("stall_done_ready", 32'(req_ready), 32'd1);

    // Op 00: no access at all.
    start_req(2'b00, 2'b10, 32'h8000_0050, 32'h1111_1111, 5'd1);
    chk("nop_enB", 32'(enB), 32'd0);
    chk("nop_req_ready", 32'(req_ready), 32'd1);

    // Load timeout.
    start_req(2'b10, 2'b10, 32'h8000_0004, 32'd0, 5'd3);
    ready = 1'b1;
    step();
    ready = 1'b0;
    k = 0; wb_seen = 0;
    while (k < 40 && !err_valid) begin
      step();
      k++;
      if (wb_valid) wb_seen++;
    end
    chk("to_err_valid", 32'(err_valid), 32'd1);
    chk("to_cycles", 32'(k), 32'd16);
    chk("to_err_code", 32'(err_code), 32'd3);
    chk("to_err_addr", err_addr, 32'h8000_0004);
    chk("to_no_wb", 32'(wb_seen), 32'd0);
    readValidB = 1'b1; addrBOut = 32'h8000_0004; doutB = 32'h5555_5555;
    step();
    readValidB = 1'b0;
    chk("stray_rvb_wb", 32'(wb_valid), 32'd0);
    chk("to_err_pulse", 32'(err_valid), 32'd0);

    // Misaligned word read.
    start_req(2'b10, 2'b10, 32'h8000_0002, 32'd0, 5'd2);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_err_valid", 32'(err_valid), 32'd1);
    chk("mis_err_code", 32'(err_code), 32'd1);
    chk("mis_err_addr", err_addr, 32'h8000_0002);
    chk("mis_enB", 32'(enB), 32'd0);
    step();
    chk("mis_enB2", 32'(enB), 32'd0);
    chk("mis_req_ready", 32'(req_ready), 32'd1);
`else
    chk("mis_enB", 32'(enB), 32'd1);
    chk("mis_alu", alu, 32'h8000_0002);
    ready = 1'b1;
    step();
    ready = 1'b0;
    readValidB = 1'b1; addrBOut = 32'h8000_0002; doutB = 32'hCAFE_F00D;
    step();
    readValidB = 1'b0;
    chk("mis_wb_valid", 32'(wb_valid), 32'd1);
    chk("mis_no_err", 32'(err_valid), 32'd0);
    step();
    start_req(2'b11, 2'b11, 32'h8000_0044, 32'h5566_7788, 5'd0);
    chk("sz11_memSize", 32'(memSize), 32'd2);
    chk("sz11_din", din, 32'h5566_7788);
    ready = 1'b1;
    step();
    ready = 1'b0;
`endif

    // Response address mismatch.
    start_req(2'b10, 2'b10, 32'h8000_0060, 32'd0, 5'd4);
    ready = 1'b1;
    step();
    ready = 1'b0;
    readValidB = 1'b1; addrBOut = 32'h8000_0064; doutB = 32'h1234_5678;
    step();
    readValidB = 1'b0;
    chk("mm_wb_valid", 32'(wb_valid), 32'd1);
    chk("mm_wb_data", wb_data, 32'h1234_5678);
    chk("mm_err_valid", 32'(err_valid), 32'd1);
    chk("mm_err_code", 32'(err_code), 32'd2);
    chk("mm_err_addr", err_addr, 32'h8000_0060);

    // Reset during WAIT_RD drops the load.
    start_req(2'b10, 2'b10, 32'h8000_0070, 32'd0, 5'd6);
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_enB", 32'(enB), 32'd0);
    chk("mrst_alu", alu, 32'd0);
    chk("mrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mrst_err_valid", 32'(err_valid), 32'd0);
    chk("mrst_err_code", 32'(err_code), 32'd0);
    #10;
    rst_n = 1'b1;
    wb_seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (wb_valid || err_valid) wb_seen++;
    end
    chk("mrst_no_strobes", 32'(wb_seen), 32'd0);
    chk("mrst_req_ready", 32'(req_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
